i2c_slave_block: RTL and testbench
==================================

Name: i2c_slave_block

Overview:
- I2C target (slave) endpoint: the bus-side counterpart of the I2C master in the same subsystem.
- Runs entirely on i2c_core_clock_i and oversamples SCL/SDA.
- Detects START, repeated START and STOP, matches a 7-bit address, and moves bytes through simple valid/ready strobes to FIFOs or registers.
- Drives SDA open-drain only; never drives SCL (no clock stretching).

Parameters:
- SYNC_STAGES, 2, flip-flop stages on scl_i/sda_i before edge detection (min 2).

Ports:
- i2c_core_clock_i  input  1  core clock; all logic on rising edge
- reset_bit_n_i  input  1  asynchronous active-low reset
- enable_i  input  1  block enable; low forces IDLE and releases SDA
- slave_addr_i  input  7  own address; sampled when the address byte completes
- scl_i  input  1  bus SCL (asynchronous)
- sda_i  input  1  bus SDA (asynchronous)
- sda_oe_o  output  1  1 = pull SDA low, 0 = release
- rx_data_o  output  8  last byte written by the master
- rx_valid_o  output  1  one-cycle pulse, rx_data_o updated
- rx_full_i  input  1  receive sink cannot accept a byte
- tx_data_i  input  8  byte to return on a master read
- tx_valid_i  input  1  tx_data_i is valid
- tx_ready_o  output  1  one-cycle pulse, tx_data_i consumed
- rw_o  output  1  R/W bit of the current addressed transfer
- busy_o  output  1  high while addressed (ADDR_ACK through end of transfer)
- start_det_o  output  1  pulse on START or repeated START
- stop_det_o  output  1  pulse on STOP
- overrun_o  output  1  pulse, write byte NACKed because rx_full_i was high
- underrun_o  output  1  pulse, read byte sent as 0xFF because tx_valid_i was low

Behaviour:
- Reset and outputs:
  - Reset value of all outputs is 0, rx_data_o = 0x00, state = IDLE.
  - Reset asserted mid-transfer releases SDA immediately (asynchronous).
- Synchronisation and edge detection:
  - scl_i/sda_i pass through SYNC_STAGES flops; edges are detected on the synchronised copies against a one-cycle-delayed copy.
  - Bus requirement: SCL high and low phases each ≥ SYNC_STAGES+3 core clocks.
- START/STOP detection:
  - START = SDA falling while SCL high. STOP = SDA rising while SCL high.
  - Both are recognised in every state, including IDLE and repeated START mid-byte.
  - START: pulse start_det_o, clear bit counter, go to ADDR, release SDA.
  - STOP: pulse stop_det_o, go to IDLE, release SDA, clear busy_o.
- SDA timing:
  - Data bits are sampled on the synchronised SCL rising edge.
  - sda_oe_o changes only on the cycle after a synchronised SCL falling edge, except for reset, STOP, START and enable_i low, which release it immediately.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits MSB first. On the 8th rising edge compare byte[7:1] with slave_addr_i.
    - Match: capture rw_o = byte[0], set busy_o, go to ADDR_ACK.
    - Mismatch: go to WAIT_STOP.
  - ADDR_ACK: drive SDA low from the 8th falling edge to the 9th falling edge. At the 9th falling edge:
    - rw=0: go to WR_BYTE and release SDA.
    - rw=1: go to RD_BYTE and load the shift register (see RD_BYTE).
  - WR_BYTE: shift 8 bits. On the 8th rising edge:
    - rx_full_i=0: rx_data_o ← byte, rx_valid_o pulses the next cycle, go to WR_ACK with ack=1.
    - rx_full_i=1: byte discarded, overrun_o pulses, go to WR_ACK with ack=0.
  - WR_ACK: drive SDA low across the 9th clock if ack=1, otherwise release. At the 9th falling edge release SDA and return to WR_BYTE.
  - RD_BYTE:
    - Shift register load: if tx_valid_i=1, load tx_data_i and pulse tx_ready_o; otherwise load 0xFF and pulse underrun_o.
    - Output: sda_oe_o = ~bit, MSB first, updated after each falling edge.
    - After the 8th falling edge release SDA and go to RD_ACK.
  - RD_ACK: sample SDA on the 9th rising edge.
    - 0 (ACK): at the 9th falling edge reload per RD_BYTE and re-enter RD_BYTE.
    - 1 (NACK): go to WAIT_STOP with SDA released.
  - WAIT_STOP: SDA released; ignore bits until START or STOP.
- enable_i low: state → IDLE and SDA released in the same cycle; no strobes are generated while low.
- Simultaneous events: START/STOP detection has priority over bit processing in the same cycle.
- Bit counter is 4 bits and wraps to 0 only on a START or on ACK-phase completion.

Test Plan:
- Write 0xA6 (addr 0x53, W) then data 0x3C, 0xF0, STOP, rx_full_i=0 -> ACK on all 3 bytes; rx_valid_o pulses twice with 0x3C then 0xF0; stop_det_o pulses once; busy_o then 0.
- Address 0x54 sent while slave_addr_i=0x53 -> SDA never driven; no rx_valid_o; state returns to IDLE on STOP.
- Read 0xA7 with tx_data_i 0x81 then 0x7E, master ACKs then NACKs -> SDA bits 10000001, 01111110; two tx_ready_o pulses; after the NACK, WAIT_STOP with SDA released.
- Read with tx_valid_i=0 -> byte 0xFF on the bus; underrun_o pulses once; tx_ready_o stays 0.
- Write with rx_full_i=1 on the 2nd data byte -> 9th bit of that byte is NACK (SDA released); overrun_o pulses once; rx_data_o keeps the prior value.
- Repeated START mid-byte (after 4 data bits) then 0xA7 -> start_det_o pulses; partial byte dropped; address re-matched; rw_o=1. Reset asserted during an ACK drive -> sda_oe_o=0 immediately.

Source files
------------

// File: rtl/i2c_slave_block_if.sv
// I2C target bus bundle: pads, rx/tx strobes and status.
// The slave modport is the block side; master is the system/bench side.
interface i2c_slave_block_if;
  logic       enable_i;
  logic [6:0] slave_addr_i;
  logic       scl_i;
  logic       sda_i;
  logic       sda_oe_o;
  logic [7:0] rx_data_o;
  logic       rx_valid_o;
  logic       rx_full_i;
  logic [7:0] tx_data_i;
  logic       tx_valid_i;
  logic       tx_ready_o;
  logic       rw_o;
  logic       busy_o;
  logic       start_det_o;
  logic       stop_det_o;
  logic       overrun_o;
  logic       underrun_o;

  modport slave (
    input  enable_i, slave_addr_i,
    input  scl_i, sda_i,
    input  rx_full_i, tx_data_i, tx_valid_i,
    output sda_oe_o, rx_data_o, rx_valid_o,
    output tx_ready_o, rw_o, busy_o,
    output start_det_o, stop_det_o,
    output overrun_o, underrun_o
  );

  modport master (
    output enable_i, slave_addr_i,
    output scl_i, sda_i,
    output rx_full_i, tx_data_i, tx_valid_i,
    input  sda_oe_o, rx_data_o, rx_valid_o,
    input  tx_ready_o, rw_o, busy_o,
    input  start_det_o, stop_det_o,
    input  overrun_o, underrun_o
  );
endinterface

// File: rtl/i2c_slave_block.sv
// I2C target: oversampled SCL/SDA, 7-bit address match,
// open-drain SDA only, no clock stretching.
module i2c_slave_block #(
  parameter int SYNC_STAGES = 2
) (
  input logic              i2c_core_clock_i,
  input logic              reset_bit_n_i,
  i2c_slave_block_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_BYTE,
    WR_ACK, RD_BYTE, RD_ACK, WAIT_STOP
  } state_e;

  state_e state_q, state_d;

  logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
  logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
  logic scl_prev_q, sda_prev_q;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic sda_oe_q, sda_oe_d;
  logic ack_q, ack_d;
  logic rw_q, rw_d;
  logic busy_q, busy_d;
  logic rx_valid_q, rx_valid_d;
  logic tx_ready_q, tx_ready_d;
  logic start_q, start_d;
  logic stop_q, stop_d;
  logic overrun_q, overrun_d;
  logic underrun_q, underrun_d;

  logic scl_s, sda_s;
  logic scl_rise, scl_fall;
  logic start_ev, stop_ev;
  logic last_bit, addr_hit, do_load;
  logic [7:0] shift_in, load_byte;

  assign scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], bus.scl_i};
  assign sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], bus.sda_i};
  assign scl_s = scl_sync_q[SYNC_STAGES-1];
  assign sda_s = sda_sync_q[SYNC_STAGES-1];

  assign scl_rise = scl_s & ~scl_prev_q;
  assign scl_fall = ~scl_s & scl_prev_q;
  assign start_ev = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop_ev  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

  assign shift_in  = {shift_q[6:0], sda_s};
  assign last_bit  = (bit_cnt_q == 4'd7);
  assign addr_hit  = (shift_in[7:1] == bus.slave_addr_i);
  assign load_byte = bus.tx_valid_i ? bus.tx_data_i : 8'hFF;

  // Sync flops reset high so an idle bus gives no spurious edge.
  always_ff @(posedge i2c_core_clock_i or negedge reset_bit_n_i) begin
    if (!reset_bit_n_i) begin
      state_q    <= IDLE;
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      rx_data_q  <= '0;
      sda_oe_q   <= 1'b0;
      ack_q      <= 1'b0;
      rw_q       <= 1'b0;
      busy_q     <= 1'b0;
      rx_valid_q <= 1'b0;
      tx_ready_q <= 1'b0;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
      overrun_q  <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      scl_prev_q <= scl_s;
      sda_prev_q <= sda_s;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      rx_data_q  <= rx_data_d;
      sda_oe_q   <= sda_oe_d;
      ack_q      <= ack_d;
      rw_q       <= rw_d;
      busy_q     <= busy_d;
      rx_valid_q <= rx_valid_d;
      tx_ready_q <= tx_ready_d;
      start_q    <= start_d;
      stop_q     <= stop_d;
      overrun_q  <= overrun_d;
      underrun_q <= underrun_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!bus.enable_i) begin
      state_d = IDLE;
    end else if (start_ev) begin
      state_d = ADDR;
    end else if (stop_ev) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        ADDR:
          if (scl_rise && last_bit)
            state_d = addr_hit ? ADDR_ACK : WAIT_STOP;
        ADDR_ACK:
          if (scl_fall && bit_cnt_q == 4'd9)
            state_d = rw_q ? RD_BYTE : WR_BYTE;
        WR_BYTE:
          if (scl_rise && last_bit) state_d = WR_ACK;
        WR_ACK:
          if (scl_fall && bit_cnt_q == 4'd9)
            state_d = WR_BYTE;
        RD_BYTE:
          if (scl_fall && last_bit) state_d = RD_ACK;
        RD_ACK:
          if (scl_rise && sda_s)
            state_d = WAIT_STOP;
          else if (scl_fall && bit_cnt_q == 4'd9)
            state_d = RD_BYTE;
        default: ;
      endcase
    end
  end

  always_comb begin
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    rx_data_d  = rx_data_q;
    sda_oe_d   = sda_oe_q;
    ack_d      = ack_q;
    rw_d       = rw_q;
    busy_d     = busy_q;
    rx_valid_d = 1'b0;
    tx_ready_d = 1'b0;
    start_d    = 1'b0;
    stop_d     = 1'b0;
    overrun_d  = 1'b0;
    underrun_d = 1'b0;
    do_load    = 1'b0;
    if (!bus.enable_i) begin
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
      bit_cnt_d = '0;
    end else if (start_ev) begin
      start_d   = 1'b1;
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
    end else if (stop_ev) begin
      stop_d   = 1'b1;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else begin
      unique case (state_q)
        ADDR:
          if (scl_rise) begin
            shift_d   = shift_in;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (last_bit && addr_hit) begin
              rw_d   = sda_s;
              busy_d = 1'b1;
            end
          end
        ADDR_ACK, WR_ACK: begin
          if (scl_rise) bit_cnt_d = 4'd9;
          if (scl_fall && bit_cnt_q == 4'd8) begin
            sda_oe_d = (state_q == ADDR_ACK) | ack_q;
          end else if (scl_fall && bit_cnt_q == 4'd9) begin
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
            do_load   = (state_q == ADDR_ACK) & rw_q;
          end
        end
        WR_BYTE:
          if (scl_rise) begin
            shift_d   = shift_in;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (last_bit) begin
              ack_d       = ~bus.rx_full_i;
              rx_valid_d  = ~bus.rx_full_i;
              overrun_d   = bus.rx_full_i;
              if (!bus.rx_full_i) rx_data_d = shift_in;
            end
          end
        // Each falling edge presents the next bit, MSB first.
        RD_BYTE:
          if (scl_fall) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (last_bit) begin
              sda_oe_d = 1'b0;
            end else begin
              shift_d  = {shift_q[6:0], 1'b0};
              sda_oe_d = ~shift_q[6];
            end
          end
        RD_ACK: begin
          if (scl_rise) bit_cnt_d = 4'd9;
          if (scl_fall && bit_cnt_q == 4'd9) begin
            bit_cnt_d = '0;
            do_load   = 1'b1;
          end
        end
        default: sda_oe_d = 1'b0;
      endcase
    end
    if (do_load) begin
      shift_d    = load_byte;
      sda_oe_d   = ~load_byte[7];
      tx_ready_d = bus.tx_valid_i;
      underrun_d = ~bus.tx_valid_i;
    end
  end

  assign bus.sda_oe_o    = sda_oe_q & bus.enable_i;
  assign bus.rx_data_o   = rx_data_q;
  assign bus.rx_valid_o  = rx_valid_q & bus.enable_i;
  assign bus.tx_ready_o  = tx_ready_q & bus.enable_i;
  assign bus.rw_o        = rw_q;
  assign bus.busy_o      = busy_q;
  assign bus.start_det_o = start_q & bus.enable_i;
  assign bus.stop_det_o  = stop_q & bus.enable_i;
  assign bus.overrun_o   = overrun_q & bus.enable_i;
  assign bus.underrun_o  = underrun_q & bus.enable_i;

endmodule

// File: tb/tb_i2c_slave_block.sv
// Directed bench: bench acts as open-drain I2C master and
// checks strobes, returned bits and ACKs against hand values.
module tb_i2c_slave_block;

  localparam int Q = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic m_scl = 1'b1;
  logic m_sda = 1'b1;
  logic line;

  int n_cmp = 0;
  int n_bad = 0;
  int n_rx = 0, n_txr = 0, n_start = 0, n_stop = 0;
  int n_ovr = 0, n_und = 0, n_oe = 0;
  logic [7:0] rx_log [$];

  i2c_slave_block_if bus ();

  i2c_slave_block #(.SYNC_STAGES(2)) dut (
    .i2c_core_clock_i (clk),
    .reset_bit_n_i    (rst_n),
    .bus              (bus)
  );

  always #5 clk = ~clk;

  assign line      = m_sda & ~bus.sda_oe_o;
  assign bus.scl_i = m_scl;
  assign bus.sda_i = line;

  always @(negedge clk) begin
    if (bus.rx_valid_o) begin
      n_rx++;
      rx_log.push_back(bus.rx_data_o);
    end
    if (bus.tx_ready_o)  n_txr++;
    if (bus.start_det_o) n_start++;
    if (bus.stop_det_o)  n_stop++;
    if (bus.overrun_o)   n_ovr++;
    if (bus.underrun_o)  n_und++;
    if (bus.sda_oe_o)    n_oe++;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic sbit(input logic b, output logic r);
    m_sda = b;
    tick(Q);
    m_scl = 1'b1;
    tick(Q);
    r = line;
    tick(Q);
    m_scl = 1'b0;
    tick(Q);
  endtask

  task automatic i2c_start();
    m_sda = 1'b1;
    tick(Q);
    m_scl = 1'b1;
    tick(Q);
    m_sda = 1'b0;
    tick(Q);
    m_scl = 1'b0;
    tick(Q);
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0;
    tick(Q);
    m_scl = 1'b1;
    tick(Q);
    m_sda = 1'b1;
    tick(2 * Q);
  endtask

  task automatic wbyte(input logic [7:0] b, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) sbit(b[i], r);
    sbit(1'b1, r);
    ack = ~r;
  endtask

  task automatic rbyte(input logic mack, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      sbit(1'b1, r);
      d[i] = r;
    end
    sbit(~mack, r);
  endtask

  initial begin
    logic ack;
    logic r;
    logic [7:0] d;
    logic [7:0] a6;
    int b_rx, b_txr, b_st, b_sp, b_ovr, b_und, b_oe;

    bus.enable_i     = 1'b1;
    bus.slave_addr_i = 7'h53;
    bus.rx_full_i    = 1'b0;
    bus.tx_data_i    = 8'h00;
    bus.tx_valid_i   = 1'b0;
    a6 = 8'hA6;

    #2 rst_n = 1'b0;
    tick(3);
    chk("rst_sda_oe", bus.sda_oe_o, 0);
    chk("rst_rx_data", bus.rx_data_o, 0);
    chk("rst_busy", bus.busy_o, 0);
    chk("rst_rw", bus.rw_o, 0);
    rst_n = 1'b1;
    tick(4);

    // Write 0x3C, 0xF0 to address 0x53.
    i2c_start();
    wbyte(8'hA6, ack);
    chk("wr_addr_ack", ack, 1);
    chk("wr_busy", bus.busy_o, 1);
    wbyte(8'h3C, ack);
    chk("wr_d0_ack", ack, 1);
    wbyte(8'hF0, ack);
    chk("wr_d1_ack", ack, 1);
    i2c_stop();
    chk("wr_rx_cnt", n_rx, 2);
    chk("wr_rx0", rx_log[0], 8'h3C);
    chk("wr_rx1", rx_log[1], 8'hF0);
    chk("wr_rx_data", bus.rx_data_o, 8'hF0);
    chk("wr_start_cnt", n_start, 1);
    chk("wr_stop_cnt", n_stop, 1);
    chk("wr_busy_end", bus.busy_o, 0);

    // Foreign address 0x54.
    b_rx = n_rx;
    b_oe = n_oe;
    i2c_start();
    wbyte(8'hA8, ack);
    chk("mis_addr_nack", ack, 0);
    wbyte(8'h55, ack);
    chk("mis_data_nack", ack, 0);
    i2c_stop();
    chk("mis_oe_cycles", n_oe - b_oe, 0);
    chk("mis_rx_cnt", n_rx - b_rx, 0);
    chk("mis_busy", bus.busy_o, 0);

    // Read 0x81 then 0x7E, ACK then NACK.
    b_txr = n_txr;
    b_und = n_und;
    bus.tx_valid_i = 1'b1;
    bus.tx_data_i  = 8'h81;
    i2c_start();
    wbyte(8'hA7, ack);
    chk("rd_addr_ack", ack, 1);
    chk("rd_rw", bus.rw_o, 1);
    bus.tx_data_i = 8'h7E;
    rbyte(1'b1, d);
    chk("rd_byte0", d, 8'h81);
    rbyte(1'b0, d);
    chk("rd_byte1", d, 8'h7E);
    chk("rd_txr_cnt", n_txr - b_txr, 2);
    chk("rd_und_cnt", n_und - b_und, 0);
    chk("rd_nack_oe", bus.sda_oe_o, 0);
    rbyte(1'b0, d);
    chk("rd_wait_stop", d, 8'hFF);
    i2c_stop();

    // Read with nothing to send.
    b_txr = n_txr;
    b_und = n_und;
    bus.tx_valid_i = 1'b0;
    i2c_start();
    wbyte(8'hA7, ack);
    chk("und_addr_ack", ack, 1);
    rbyte(1'b0, d);
    chk("und_byte", d, 8'hFF);
    chk("und_cnt", n_und - b_und, 1);
    chk("und_txr_cnt", n_txr - b_txr, 0);
    i2c_stop();

    // Receive sink full on the second data byte.
    b_rx  = n_rx;
    b_ovr = n_ovr;
    i2c_start();
    wbyte(8'hA6, ack);
    wbyte(8'h11, ack);
    chk("ovr_d0_ack", ack, 1);
    bus.rx_full_i = 1'b1;
    wbyte(8'h22, ack);
    chk("ovr_d1_nack", ack, 0);
    bus.rx_full_i = 1'b0;
    chk("ovr_cnt", n_ovr - b_ovr, 1);
    chk("ovr_rx_cnt", n_rx - b_rx, 1);
    chk("ovr_rx_data", bus.rx_data_o, 8'h11);
    i2c_stop();

    // Repeated START after four data bits.
    b_rx = n_rx;
    b_st = n_start;
    b_sp = n_stop;
    bus.tx_valid_i = 1'b1;
    bus.tx_data_i  = 8'hC3;
    i2c_start();
    wbyte(8'hA6, ack);
    sbit(1'b1, r);
    sbit(1'b0, r);
    sbit(1'b1, r);
    sbit(1'b0, r);
    i2c_start();
    wbyte(8'hA7, ack);
    chk("rs_addr_ack", ack, 1);
    chk("rs_rw", bus.rw_o, 1);
    chk("rs_start_cnt", n_start - b_st, 2);
    chk("rs_stop_cnt", n_sp_dummy(b_sp), 0);
    rbyte(1'b0, d);
    chk("rs_byte", d, 8'hC3);
    chk("rs_rx_cnt", n_rx - b_rx, 0);
    i2c_stop();

    // Reset while the address ACK is on the bus.
    i2c_start();
    for (int i = 7; i >= 0; i--) sbit(a6[i], r);
    m_sda = 1'b1;
    tick(Q);
    m_scl = 1'b1;
    tick(2);
    chk("ack_drive", bus.sda_oe_o, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_async_oe", bus.sda_oe_o, 0);
    tick(Q);
    rst_n = 1'b1;
    tick(Q);
    chk("rst_busy_end", bus.busy_o, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  function automatic int n_sp_dummy(input int base);
    return n_stop - base;
  endfunction

endmodule
